// File: rtl/hex_event_reader.sv
// Purpose : read side of the hex event buffer. Fetches event_count 64-bit records from buffer_base,
//           unpacks them to (q, r, depth, material) and streams them in order on a valid/ready port.
// Latency : first mem_re one cycle after frame_start; response to valid_out is one cycle when the FIFO is empty.
// Backpres: reads are credit-limited so outstanding + FIFO occupancy never exceeds FIFO_DEPTH.
//           mem_rvalid is therefore never stalled, and ready_in low stops fetching once credit runs out.
// Ports   : clk/reset (async, active-high); frame_start/buffer_base/event_count start a frame;
//           mem_addr/mem_re/mem_ready form the request port; mem_rvalid/mem_rdata return in-order responses;
//           valid_out/ready_in/q/r/depth/material form the event stream; busy and frame_done give frame status.
// Option  : define HEX_READER_DEPTH_CULL_EN to add depth_max. It is latched at frame_start, and records
//           deeper than depth_max are dropped on return.

// Small in-order FIFO with a synchronous flush. A push is accepted when the FIFO is full if a pop
// happens in the same cycle.
module hex_event_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     wr_vld_i,
  input  logic [W-1:0]             wr_dat_i,
  output logic                     rd_vld_o,
  input  logic                     rd_rdy_i,
  output logic [W-1:0]             rd_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          push, pop;

  assign pop      = rd_rdy_i && (cnt_q != '0);
  assign push     = wr_vld_i && ((cnt_q != (AW+1)'(DEPTH)) || pop);
  assign rd_vld_o = (cnt_q != '0);
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign count_o  = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= wr_dat_i;
  end
endmodule

module hex_event_reader #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_STRIDE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [31:0]        buffer_base,
  input  logic [31:0]        event_count,
`ifdef HEX_READER_DEPTH_CULL_EN
  input  logic [7:0]         depth_max,
`endif
  output logic [31:0]        mem_addr,
  output logic               mem_re,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [63:0]        mem_rdata,
  output logic               valid_out,
  input  logic               ready_in,
  output logic signed [15:0] q,
  output logic signed [15:0] r,
  output logic [7:0]         depth,
  output logic [7:0]         material,
  output logic               busy,
  output logic               frame_done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;  // holds 0..FIFO_DEPTH

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d, count_q, count_d;
  logic [31:0]   issued_q, issued_d, accepted_q, accepted_d;
  logic [CW-1:0] outst_q, outst_d;      // requests of the current frame still owed a response
  logic [CW-1:0] discard_q, discard_d;  // responses still owed to an aborted frame
  logic [CW-1:0] fifo_cnt;
  logic [CW+1:0] credit_used;
  logic          issue, resp_old, resp_cur, cull, push, pop, fifo_vld;
  logic [47:0]   fifo_head;
  logic          unused_rsvd;

  assign unused_rsvd = ^mem_rdata[15:0];

  // Credit is the only thing that can drop mem_re while a request is pending. Credit only shrinks
  // on an accepted request, so a pending request stays stable until mem_ready accepts it.
  assign credit_used = (CW+2)'(outst_q) + (CW+2)'(discard_q) + (CW+2)'(fifo_cnt);
  assign mem_re      = (state_q == FETCH) && (issued_q != count_q) &&
                       (credit_used < (CW+2)'(FIFO_DEPTH));
  assign mem_addr    = base_q + issued_q * 32'(ADDR_STRIDE);
  assign issue       = mem_re && mem_ready;

  // Old-frame responses come first because responses return in order.
  assign resp_old = mem_rvalid && (discard_q != '0);
  assign resp_cur = mem_rvalid && (discard_q == '0) && (outst_q != '0);

`ifdef HEX_READER_DEPTH_CULL_EN
  logic [7:0] depth_max_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            depth_max_q <= '0;
    else if (frame_start) depth_max_q <= depth_max;
  end
  assign cull = resp_cur && (mem_rdata[31:24] > depth_max_q);
`else
  assign cull = 1'b0;
`endif

  // A response arriving on the restart cycle belongs to the old frame and is dropped.
  assign push = resp_cur && !cull && !frame_start;
  assign pop  = fifo_vld && ready_in;

  hex_event_fifo #(.W(48), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i    (clk),
    .rst_i    (reset),
    .flush_i  (frame_start),
    .wr_vld_i (push),
    .wr_dat_i (mem_rdata[63:16]),
    .rd_vld_o (fifo_vld),
    .rd_rdy_i (ready_in),
    .rd_dat_o (fifo_head),
    .count_o  (fifo_cnt)
  );

  assign valid_out                 = fifo_vld;
  assign {q, r, depth, material}   = fifo_vld ? fifo_head : 48'd0;
  assign busy                      = (state_q == FETCH) || (state_q == DRAIN);
  assign frame_done                = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    issued_d   = issued_q + 32'(issue);
    accepted_d = accepted_q + 32'(pop) + 32'(cull);  // culled records count as accepted
    outst_d    = outst_q + CW'(issue) - CW'(resp_cur);
    discard_d  = discard_q - CW'(resp_old);
    case (state_q)
      IDLE:  state_d = IDLE;
      FETCH: if (issued_d == count_q) state_d = (accepted_d == count_q) ? DONE : DRAIN;
      DRAIN: if (accepted_d == count_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (frame_start) begin
      // Any request still owed (including one accepted this cycle) moves to the discard count.
      base_d     = buffer_base;
      count_d    = event_count;
      issued_d   = '0;
      accepted_d = '0;
      discard_d  = discard_d + outst_d;
      outst_d    = '0;
      state_d    = (event_count == 32'd0) ? DONE : FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end
endmodule

// File: tb/tb_hex_event_reader.sv
`timescale 1ns/1ps
module tb_hex_event_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [31:0] buffer_base = '0;
  logic [31:0] event_count = '0;
  logic [7:0]  depth_max = 8'hFF;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic signed [15:0] q, r;
  logic [7:0]  depth, material;
  logic        busy, frame_done;

  hex_event_reader #(.FIFO_DEPTH(4), .ADDR_STRIDE(8)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .buffer_base(buffer_base), .event_count(event_count),
`ifdef HEX_READER_DEPTH_CULL_EN
    .depth_max(depth_max),
`endif
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .valid_out(valid_out), .ready_in(ready_in),
    .q(q), .r(r), .depth(depth), .material(material),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int lat = 1;
  bit hold = 1'b0;
  logic [31:0] addrs[$];
  logic [47:0] got[$];
  logic [31:0] pend_a[$];
  int          pend_t[$];
  int re_cnt = 0, done_cnt = 0, rv_cnt = 0, last_acc = -1, last_done = -1;
  logic [63:0] mem_tbl [logic [31:0]];

  function automatic logic [63:0] rec(input logic [31:0] a);
    if (mem_tbl.exists(a)) return mem_tbl[a];
    return {a[15:0], ~a[15:0], a[7:0], a[11:4], 16'hBEEF};
  endfunction

  function automatic logic [47:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and stream monitor, evaluated mid-cycle so every observation is away from the edge.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (pend_a.size() > 0 && pend_t[0] == 0 && !hold) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rec(pend_a[0]);
      void'(pend_a.pop_front());
      void'(pend_t.pop_front());
      rv_cnt++;
    end
    foreach (pend_t[i]) if (pend_t[i] > 0) pend_t[i]--;
    if (!reset) begin
      if (mem_re && mem_ready) begin
        pend_a.push_back(mem_addr);
        pend_t.push_back(lat - 1);
        addrs.push_back(mem_addr);
      end
      if (mem_re) re_cnt++;
      if (valid_out && ready_in) begin
        got.push_back({q, r, depth, material});
        last_acc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        last_done = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addrs.delete();
    got.delete();
    re_cnt = 0; done_cnt = 0; rv_cnt = 0; last_acc = -1; last_done = -1;
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] cnt);
    buffer_base = base;
    event_count = cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (done_cnt == 0 && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        bad;
    logic [31:0] a;
    logic [63:0] full;

    // Reset state
    tick(); tick();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_qrdm", {q, r, depth, material}, 0);
    chk("rst_busy_done", {busy, frame_done}, 0);

    // Reset mid-frame with two reads outstanding
    reset = 1'b0; mem_ready = 1'b1; ready_in = 1'b1; hold = 1'b1; lat = 1;
    tick();
    clear_logs();
    start(32'h3000, 5);
    chk("rm_busy", busy, 1);
    chk("rm_re", mem_re, 1);
    chk("rm_addr", mem_addr, 32'h3000);
    tick(); tick();
    mem_ready = 1'b0;
    chk("rm_issued", addrs.size(), 2);
    reset = 1'b1;
    #1;
    chk("rm_busy_in_rst", busy, 0);
    chk("rm_re_in_rst", mem_re, 0);
    tick();
    reset = 1'b0; mem_ready = 1'b1; hold = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      tick();
      bad = bad | busy | valid_out | mem_re | frame_done | (q != 0) | (r != 0) |
            (depth != 0) | (material != 0);
    end
    chk("rm_quiet", bad, 0);
    chk("rm_late_rvalid", rv_cnt, 2);
    chk("rm_no_events", got.size(), 0);

    // Basic frame, 2-cycle latency
    lat = 2;
    mem_tbl[32'h1000] = 64'h0005FFFD_7F030000;
    mem_tbl[32'h1008] = 64'hFFFF0001_01020000;
    mem_tbl[32'h1010] = 64'h1234ABCD_40FFBEEF;
    clear_logs();
    start(32'h1000, 3);
    chk("bf_busy", busy, 1);
    chk("bf_re", mem_re, 1);
    chk("bf_addr0", mem_addr, 32'h1000);
    wait_done("bf", 60);
    chk("bf_naddr", addrs.size(), 3);
    chk("bf_addr1", addrs[1], 32'h1008);
    chk("bf_addr2", addrs[2], 32'h1010);
    chk("bf_nev", got.size(), 3);
    chk("bf_ev0", got_at(0), 48'h0005_FFFD_7F03);
    chk("bf_ev1", got_at(1), 48'hFFFF_0001_0102);
    chk("bf_ev2", got_at(2), 48'h1234_ABCD_40FF);
    chk("bf_done_once", done_cnt, 1);
    chk("bf_done_timing", last_done, last_acc + 1);
    chk("bf_idle", {busy, frame_done}, 0);

    // Backpressure: credit caps outstanding + buffered at 4
    lat = 1; ready_in = 1'b0;
    clear_logs();
    start(32'h4000, 10);
    repeat (20) tick();
    chk("bp_issued", addrs.size(), 4);
    chk("bp_re_low", mem_re, 0);
    chk("bp_valid", valid_out, 1);
    ready_in = 1'b1;
    wait_done("bp", 100);
    chk("bp_nev", got.size(), 10);
    for (int i = 0; i < 10; i++) begin
      a = 32'h4000 + 32'(i * 8);
      full = {a[15:0], ~a[15:0], a[7:0], a[11:4], 16'hBEEF};
      chk($sformatf("bp_ev%0d", i), got_at(i), full[63:16]);
    end

    // Zero-length frame
    clear_logs();
    start(32'h5000, 0);
    chk("z_done", frame_done, 1);
    chk("z_busy", busy, 0);
    tick();
    chk("z_done_pulse", frame_done, 0);
    repeat (3) tick();
    chk("z_no_re", re_cnt, 0);

    // Address wrap
    clear_logs();
    start(32'hFFFF_FFF8, 2);
    wait_done("wr", 40);
    chk("wr_naddr", addrs.size(), 2);
    chk("wr_addr0", addrs[0], 32'hFFFF_FFF8);
    chk("wr_addr1", addrs[1], 32'h0000_0000);
    chk("wr_ev0", got_at(0), 48'hFFF8_0007_F8FF);
    chk("wr_ev1", got_at(1), 48'h0000_FFFF_0000);

    // Abort with three old reads outstanding
    hold = 1'b1;
    clear_logs();
    start(32'h6000, 8);
    tick(); tick(); tick();
    mem_ready = 1'b0;
    chk("ab_old_issued", addrs.size(), 3);
    clear_logs();
    start(32'h2000, 1);
    mem_ready = 1'b1; hold = 1'b0;
    wait_done("ab", 60);
    chk("ab_naddr", addrs.size(), 1);
    chk("ab_addr", addrs[0], 32'h2000);
    chk("ab_nev", got.size(), 1);
    chk("ab_ev", got_at(0), 48'h2000_DFFF_0000);
    chk("ab_done_once", done_cnt, 1);

`ifdef HEX_READER_DEPTH_CULL_EN
    // Depth cull
    mem_tbl[32'h7000] = 64'h0001_0002_10AA_0000;
    mem_tbl[32'h7008] = 64'h0003_0004_80BB_0000;
    mem_tbl[32'h7010] = 64'h0005_0006_40CC_0000;
    depth_max = 8'h40;
    clear_logs();
    start(32'h7000, 3);
    wait_done("cu", 60);
    chk("cu_nev", got.size(), 2);
    chk("cu_ev0", got_at(0), 48'h0001_0002_10AA);
    chk("cu_ev1", got_at(1), 48'h0005_0006_40CC);
    chk("cu_done_timing", last_done, last_acc + 1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
